spi_rom_burst_ctrl: RTL and testbench

Burst-read sequencer for the 8-bit lookup ROM on the SPI datapath. It takes a start address and a byte count, and walks the ROM address bus one address at a time. Each ROM output byte is registered and handed to the SPI transmit shifter over a valid/ready handshake. It sits between the SPI command decoder (start/abort) and the SPI TX shifter (consumer).

---
 rtl/spi_rom_burst_ctrl_if.sv | 30 +++
 rtl/spi_rom_burst_ctrl.sv | 114 +++++++++++
 tb/tb_spi_rom_burst_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_rom_burst_ctrl_if.sv
// Command, ROM and TX signals of the SPI ROM burst sequencer, in one bundle.
// master = the sequencer itself; slave = the decoder/ROM/shifter side.
interface spi_rom_burst_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [7:0]        burst_len;
  logic              abort;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              done;

  // A byte moves when tx_valid and tx_ready are both high at a rising edge.
  // Once tx_valid rises, tx_data stays fixed until that transfer or an abort.
  modport master (
    input  start, start_addr, burst_len, abort, rom_data, tx_ready,
    output rom_addr, tx_data, tx_valid, busy, done
  );

  modport slave (
    output start, start_addr, burst_len, abort, rom_data, tx_ready,
    input  rom_addr, tx_data, tx_valid, busy, done
  );
endinterface

// File: rtl/spi_rom_burst_ctrl.sv
// Burst-read sequencer: walks a combinational ROM from a start address and
// hands each registered byte to the SPI TX shifter over valid/ready.
module spi_rom_burst_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  spi_rom_burst_ctrl_if.master   bus,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q,    state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0] tx_data_q,  tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              done_q,     done_d;
  // Nine bits so a burst_len of 0 can be held as 256.
  logic [8:0]        count_q,    count_d;

  logic [ADDR_W-1:0] addr_inc;
  logic [8:0]        len_load;

  assign addr_inc = rom_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign len_load = (bus.burst_len == 8'd0) ? 9'd256 : {1'b0, bus.burst_len};

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    count_d    = count_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          rom_addr_d = bus.start_addr;
          count_d    = len_load;
          state_d    = S_FETCH;
        end
      end

      S_FETCH: begin
        if (bus.abort) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          tx_data_d  = bus.rom_data;
          tx_valid_d = 1'b1;
          state_d    = S_SEND;
        end
      end

      S_SEND: begin
        // An abort beats a same-cycle handshake: the byte is gone, but the
        // address and count are left where they were.
        if (bus.abort) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end else if (bus.tx_ready) begin
          tx_valid_d = 1'b0;
          count_d    = count_q - 9'd1;
          rom_addr_d = addr_inc;
          state_d    = (count_q == 9'd1) ? S_DONE : S_FETCH;
        end
      end

      S_DONE: begin
        tx_valid_d = 1'b0;
        state_d    = S_IDLE;
      end

      default: begin
        tx_valid_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase

    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= 9'd0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
      count_q    <= count_d;
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.done     = done_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_spi_rom_burst_ctrl.sv
// Bench for spi_rom_burst_ctrl: directed bursts then random bursts against a
// model that lists the ROM bytes a burst must deliver, in order.
module tb_spi_rom_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  spi_rom_burst_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  spi_rom_burst_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  logic [7:0] rom_mem [256];
  assign bus.rom_data = rom_mem[bus.rom_addr];

  logic [7:0] exp_q  [$];
  logic [7:0] addr_q [$];
  int checks = 0;
  int errors = 0;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic fill_rom_inc();
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'(i + 1);
  endtask

  task automatic fill_rom_rand();
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom);
  endtask

  // abort_at: raise abort in the cycle after that many handshakes (0 = never).
  // busy_start_at: pulse a bogus start once that many handshakes are done (-1 = never).
  task automatic run_burst(input logic [7:0] sa, input logic [7:0] len, input int ready_pct,
                           input int stall, input int abort_at, input int busy_start_at);
    int n, hs_cnt, cyc, stalled;
    bit hs, last_done, pend_abort, injected;
    logic [7:0] a;
    n = (len == 8'd0) ? 256 : int'(len);
    exp_q.delete();
    addr_q.delete();
    for (int i = 0; i < n; i++) begin
      a = sa + 8'(i);
      addr_q.push_back(a);
      exp_q.push_back(rom_mem[a]);
    end
    hs_cnt = 0; cyc = 0; stalled = 0;
    last_done = 1'b0; pend_abort = 1'b0; injected = 1'b0;

    bus.start = 1'b1; bus.start_addr = sa; bus.burst_len = len; bus.tx_ready = 1'b0;
    tick();
    bus.start = 1'b0;
    bus.start_addr = 8'($urandom);
    bus.burst_len  = 8'($urandom);
    chk("fetch_busy",  32'(bus.busy), 32'd1);
    chk("fetch_valid", 32'(bus.tx_valid), 32'd0);
    chk("fetch_addr",  32'(bus.rom_addr), 32'(sa));
    tick();
    chk("first_valid_latency", 32'(bus.tx_valid), 32'd1);

    while (1) begin
      if (cyc > 4 * n + 64) begin
        chk("burst_timeout_handshakes", 32'(hs_cnt), 32'(n));
        return;
      end
      if (pend_abort) begin
        bus.abort = 1'b1;
        bus.tx_ready = 1'($urandom_range(0, 1));
        tick();
        bus.abort = 1'b0;
        chk("abort_valid", 32'(bus.tx_valid), 32'd0);
        chk("abort_busy",  32'(bus.busy), 32'd0);
        chk("abort_done",  32'(bus.done), 32'd0);
        tick();
        chk("abort_no_late_done", 32'(bus.done), 32'd0);
        chk("abort_still_idle",   32'(bus.busy), 32'd0);
        return;
      end
      if (last_done) begin
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("done_busy",  32'(bus.busy), 32'd1);
        chk("done_valid", 32'(bus.tx_valid), 32'd0);
        tick();
        chk("done_clear", 32'(bus.done), 32'd0);
        chk("idle_busy",  32'(bus.busy), 32'd0);
        return;
      end
      chk("no_early_done", 32'(bus.done), 32'd0);
      if (addr_q.size() > 0) chk("rom_addr", 32'(bus.rom_addr), 32'(addr_q[0]));
      if (bus.tx_valid) begin
        if (exp_q.size() > 0) chk("tx_data", 32'(bus.tx_data), 32'(exp_q[0]));
        else chk("extra_tx_valid", 32'(bus.tx_valid), 32'd0);
      end
      if (busy_start_at >= 0 && hs_cnt == busy_start_at && !injected) begin
        bus.start = 1'b1; bus.start_addr = 8'h80; bus.burst_len = 8'd7;
        injected = 1'b1;
      end
      if (bus.tx_valid && stalled < stall) begin
        bus.tx_ready = 1'b0;
        stalled++;
      end else begin
        bus.tx_ready = ($urandom_range(1, 100) <= ready_pct);
      end
      hs = bus.tx_valid && bus.tx_ready;
      tick();
      bus.start = 1'b0;
      cyc++;
      if (hs) begin
        void'(exp_q.pop_front());
        void'(addr_q.pop_front());
        hs_cnt++;
        if (hs_cnt == n) last_done = 1'b1;
        else if (hs_cnt == abort_at) pend_abort = 1'b1;
      end
    end
  endtask

  initial begin
    int n, ab, bs;
    logic [7:0] len;
    rst = 1'b1;
    bus.start = 1'b0; bus.start_addr = '0; bus.burst_len = '0;
    bus.abort = 1'b0; bus.tx_ready = 1'b0;
    fill_rom_inc();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_rom_addr", 32'(bus.rom_addr), 32'd0);
    chk("reset_tx_data",  32'(bus.tx_data), 32'd0);
    chk("reset_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("reset_busy",     32'(bus.busy), 32'd0);
    chk("reset_done",     32'(bus.done), 32'd0);
    bus.tx_ready = 1'b1;
    repeat (2) tick();
    chk("idle_ready_ignored", 32'(bus.tx_valid), 32'd0);

    run_burst(8'h10, 8'd3, 100, 0, 0, -1);
    run_burst(8'hFE, 8'd3, 100, 0, 0, -1);
    run_burst(8'h00, 8'd0, 100, 0, 0, -1);
    run_burst(8'h40, 8'd2, 100, 5, 0, -1);
    run_burst(8'h60, 8'd4, 100, 0, 2, -1);
    run_burst(8'h20, 8'd1, 100, 0, 0, -1);
    run_burst(8'h30, 8'd4, 100, 0, 0, 1);

    // start and abort together in IDLE: abort wins
    bus.start = 1'b1; bus.abort = 1'b1; bus.start_addr = 8'h33; bus.burst_len = 8'd2;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("start_abort_busy",  32'(bus.busy), 32'd0);
    tick();
    chk("start_abort_valid", 32'(bus.tx_valid), 32'd0);

    // reset in the middle of a burst
    bus.start = 1'b1; bus.start_addr = 8'h50; bus.burst_len = 8'd10; bus.tx_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    chk("pre_reset_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_reset_rom_addr", 32'(bus.rom_addr), 32'd0);
    chk("mid_reset_tx_data",  32'(bus.tx_data), 32'd0);
    chk("mid_reset_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("mid_reset_busy",     32'(bus.busy), 32'd0);
    chk("mid_reset_done",     32'(bus.done), 32'd0);
    tick();
    chk("post_reset_done", 32'(bus.done), 32'd0);
    chk("post_reset_busy", 32'(bus.busy), 32'd0);

    fill_rom_rand();
    for (int k = 0; k < 25; k++) begin
      len = 8'($urandom_range(1, 24));
      n = int'(len);
      ab = (n > 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, n - 1)) : 0;
      bs = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      run_burst(8'($urandom), len, int'($urandom_range(30, 100)),
                int'($urandom_range(0, 3)), ab, bs);
      bus.tx_ready = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
